// File: rtl/trigger_gen.sv
// Threshold trigger in front of the acquisition/DMA stage: forwards the sample stream one
// register late and frames events with START_TRG / FINALIZE_TRG / TIME_STAMP.
module trigger_gen #(
  parameter int THRESHOLD            = 10,
  parameter int POST_ACQUI_LEN       = 38,
  parameter int ACQUI_LEN            = 100,
  parameter int HOLDOFF_LEN          = 2,
  parameter int TIME_STAMP_WIDTH     = 16,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int S_AXIS_TDATA_WIDTH   = 128
) (
  input  logic                          AXIS_ACLK,
  input  logic                          AXIS_ARESET,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                          S_AXIS_TVALID,
  output logic                          S_AXIS_TREADY,
  output logic [S_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  input  logic                          FIFO_FULL,
  output logic                          START_TRG,
  output logic                          FINALIZE_TRG,
  output logic [TIME_STAMP_WIDTH-1:0]   TIME_STAMP,
  output logic [15:0]                   DROP_CNT
);

  localparam int NUM_LANES = S_AXIS_TDATA_WIDTH / 16;
  localparam int ADC_W     = ADC_RESOLUTION_WIDTH;
  localparam longint LEVEL      = (longint'(THRESHOLD) * (longint'(1) << ADC_W)) / 100;
  // A level beyond full scale can never be reached; clamp so it still fits the compare width.
  localparam longint LEVEL_CLMP = (LEVEL > (longint'(1) << ADC_W)) ? (longint'(1) << ADC_W) : LEVEL;
  localparam logic [ADC_W:0] LEVEL_C = LEVEL_CLMP[ADC_W:0];

  localparam int BEAT_W  = $clog2(ACQUI_LEN + 1) + 1;
  localparam int QUIET_W = $clog2(POST_ACQUI_LEN + 1) + 1;
  localparam int HOLD_W  = $clog2(HOLDOFF_LEN + 1) + 1;
  localparam logic [BEAT_W-1:0]  ACQUI_LEN_C = BEAT_W'(ACQUI_LEN);
  localparam logic [QUIET_W-1:0] POST_LEN_C  = QUIET_W'(POST_ACQUI_LEN);
  localparam logic [HOLD_W-1:0]  HOLD_LAST_C = HOLD_W'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_HOLDOFF} state_t;

  localparam state_t AFTER_EVENT = (HOLDOFF_LEN > 0) ? ST_HOLDOFF : ST_IDLE;

  logic [NUM_LANES-1:0] lane_hit;
  logic                 hit;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [ADC_W-1:0] sample;
      logic [ADC_W-1:0] mag;

      assign sample = S_AXIS_TDATA[16*gi+15 -: ADC_W];

      // Most-negative code has no positive twin; saturate it to positive full scale.
      always_comb begin
        if (sample == {1'b1, {(ADC_W-1){1'b0}}}) begin
          mag = {1'b0, {(ADC_W-1){1'b1}}};
        end else if (sample[ADC_W-1]) begin
          mag = ~sample + 1'b1;
        end else begin
          mag = sample;
        end
      end

      assign lane_hit[gi] = ({1'b0, mag} >= LEVEL_C);
    end
  endgenerate

  assign hit = S_AXIS_TVALID && (|lane_hit);

  state_t                         state_reg, state_next;
  logic [BEAT_W-1:0]              beat_cnt_reg, beat_cnt_next;
  logic [QUIET_W-1:0]             quiet_cnt_reg, quiet_cnt_next;
  logic [HOLD_W-1:0]              hold_cnt_reg, hold_cnt_next;
  logic [TIME_STAMP_WIDTH-1:0]    ts_cnt_reg;
  logic [TIME_STAMP_WIDTH-1:0]    ts_latch_reg, ts_latch_next;
  logic [15:0]                    drop_cnt_reg, drop_cnt_next;
  logic                           start_reg, start_next;
  logic                           finalize_reg, finalize_next;
  logic                           tready_reg;
  logic [S_AXIS_TDATA_WIDTH-1:0]  tdata_reg;
  logic                           tvalid_reg;
  logic [BEAT_W-1:0]              beat_inc;
  logic [QUIET_W-1:0]             quiet_inc;

  assign beat_inc  = beat_cnt_reg + 1'b1;
  assign quiet_inc = hit ? '0 : quiet_cnt_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    beat_cnt_next  = beat_cnt_reg;
    quiet_cnt_next = quiet_cnt_reg;
    hold_cnt_next  = hold_cnt_reg;
    ts_latch_next  = ts_latch_reg;
    drop_cnt_next  = drop_cnt_reg;
    start_next     = 1'b0;
    finalize_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (hit && !FIFO_FULL) begin
          start_next     = 1'b1;
          beat_cnt_next  = BEAT_W'(1);
          quiet_cnt_next = '0;
          ts_latch_next  = ts_cnt_reg;
          hold_cnt_next  = '0;
          if (ACQUI_LEN <= 1) begin
            finalize_next = 1'b1;
            state_next    = AFTER_EVENT;
          end else begin
            state_next = ST_ACQUIRE;
          end
        end else if (hit && (drop_cnt_reg != 16'hFFFF)) begin
          drop_cnt_next = drop_cnt_reg + 16'd1;
        end
      end

      ST_ACQUIRE: begin
        // Event stays open across invalid beats; only valid beats advance the counters.
        start_next = 1'b1;
        if (S_AXIS_TVALID) begin
          beat_cnt_next  = beat_inc;
          quiet_cnt_next = quiet_inc;
          if ((beat_inc >= ACQUI_LEN_C) || (quiet_inc >= POST_LEN_C)) begin
            finalize_next = 1'b1;
            hold_cnt_next = '0;
            state_next    = AFTER_EVENT;
          end
        end
      end

      ST_HOLDOFF: begin
        hold_cnt_next = hold_cnt_reg + 1'b1;
        if (hold_cnt_reg >= HOLD_LAST_C) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state_reg     <= ST_IDLE;
      beat_cnt_reg  <= '0;
      quiet_cnt_reg <= '0;
      hold_cnt_reg  <= '0;
      ts_cnt_reg    <= '0;
      ts_latch_reg  <= '0;
      drop_cnt_reg  <= '0;
      start_reg     <= 1'b0;
      finalize_reg  <= 1'b0;
      tready_reg    <= 1'b0;
      tdata_reg     <= '0;
      tvalid_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beat_cnt_reg  <= beat_cnt_next;
      quiet_cnt_reg <= quiet_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      ts_cnt_reg    <= ts_cnt_reg + 1'b1;
      ts_latch_reg  <= ts_latch_next;
      drop_cnt_reg  <= drop_cnt_next;
      start_reg     <= start_next;
      finalize_reg  <= finalize_next;
      tready_reg    <= 1'b1;
      tdata_reg     <= S_AXIS_TDATA;
      tvalid_reg    <= S_AXIS_TVALID;
    end
  end

  assign S_AXIS_TREADY = tready_reg;
  assign M_AXIS_TDATA  = tdata_reg;
  assign M_AXIS_TVALID = tvalid_reg;
  assign START_TRG     = start_reg;
  assign FINALIZE_TRG  = finalize_reg;
  assign TIME_STAMP    = ts_latch_reg;
  assign DROP_CNT      = drop_cnt_reg;

endmodule

// File: tb/tb_trigger_gen.sv
// Directed bench for trigger_gen: stimulus pushes expected events, a monitor frames
// START_TRG/FINALIZE_TRG windows and checks each against the queue.
module tb_trigger_gen;

  logic         clk = 1'b0;
  logic         AXIS_ARESET;
  logic [127:0] S_AXIS_TDATA;
  logic         S_AXIS_TVALID;
  logic         S_AXIS_TREADY;
  logic [127:0] M_AXIS_TDATA;
  logic         M_AXIS_TVALID;
  logic         FIFO_FULL;
  logic         START_TRG;
  logic         FINALIZE_TRG;
  logic [15:0]  TIME_STAMP;
  logic [15:0]  DROP_CNT;

  trigger_gen dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (AXIS_ARESET),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .FIFO_FULL     (FIFO_FULL),
    .START_TRG     (START_TRG),
    .FINALIZE_TRG  (FINALIZE_TRG),
    .TIME_STAMP    (TIME_STAMP),
    .DROP_CNT      (DROP_CNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  ts;
    logic [127:0] data;
    int           beats;
    int           cycles;
    int           gap;
    bit           abort;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [15:0] ts, input logic [127:0] d, input int beats,
                      input int cycles, input int gap, input bit abort);
    exp_t e;
    e.ts = ts; e.data = d; e.beats = beats; e.cycles = cycles; e.gap = gap; e.abort = abort;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  exp_t cur;
  bit   in_ev  = 0;
  bit   ts_bad = 0;
  int   nb = 0, nc = 0, gap_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (START_TRG && !in_ev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got ts=%0d, expected no event", TIME_STAMP);
          cur = '{ts: 16'h0, data: 128'h0, beats: 0, cycles: 0, gap: 0, abort: 1'b0};
        end else begin
          cur = exp_q.pop_front();
          chk("trigger_ts", TIME_STAMP, cur.ts);
          chk("trigger_data", M_AXIS_TDATA, cur.data);
          if (cur.gap > 0) chk("event_gap", gap_cnt, cur.gap);
        end
        in_ev = 1; nb = 0; nc = 0; ts_bad = 0;
      end
      if (in_ev) begin
        if (START_TRG) begin
          nc++;
          if (M_AXIS_TVALID) nb++;
          if (TIME_STAMP !== cur.ts) ts_bad = 1;
          if (FINALIZE_TRG) begin
            $display("event ts=%0d beats=%0d cycles=%0d", cur.ts, nb, nc);
            chk("event_beats", nb, cur.beats);
            chk("event_cycles", nc, cur.cycles);
            chk("event_not_aborted", 0, cur.abort);
            chk("ts_held", ts_bad, 0);
            in_ev = 0;
            gap_cnt = 0;
          end
        end else begin
          $display("event ts=%0d ended without finalize after %0d beats", cur.ts, nb);
          chk("event_aborted", 1, cur.abort);
          in_ev = 0;
          gap_cnt = 0;
        end
      end else begin
        gap_cnt++;
        if (FINALIZE_TRG) chk("finalize_outside_event", FINALIZE_TRG, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic beat(input logic [127:0] d, input logic v, input logic f);
    S_AXIS_TDATA = d; S_AXIS_TVALID = v; FIFO_FULL = f;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle_to(input int c);
    while (cyc < c) beat(128'h0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    AXIS_ARESET = 1'b1;
    S_AXIS_TDATA = '0; S_AXIS_TVALID = 1'b0; FIFO_FULL = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", START_TRG, 0);
    chk("rst_finalize", FINALIZE_TRG, 0);
    chk("rst_tvalid", M_AXIS_TVALID, 0);
    chk("rst_tdata", M_AXIS_TDATA, 0);
    chk("rst_ts", TIME_STAMP, 0);
    chk("rst_drop", DROP_CNT, 0);
    chk("rst_tready", S_AXIS_TREADY, 0);
    AXIS_ARESET = 1'b0;
    cyc = 0;
  endtask

  logic [127:0] h3, l0, below, neg7, pos_fs, m409;

  initial begin
    h3     = 128'h1990 << 48;    // lane 3 = +409
    l0     = 128'h1990;          // lane 0 = +409
    below  = 128'hE680_1980_E680_1980_E680_1980_E680_1980; // +/-408
    neg7   = 128'h8000 << 112;   // lane 7 = -2048
    pos_fs = 128'h7FF0;          // lane 0 = +2047
    m409   = 128'hE670 << 16;    // lane 1 = -409

    do_reset();
    mon_en = 1;
    beat(128'h0, 1'b1, 1'b0);
    chk("tready_after_reset", S_AXIS_TREADY, 1);

    // Single hit at cycle 10: 39-beat event, TIME_STAMP 10.
    do_reset();
    push(16'd10, h3, 39, 39, 0, 0);
    idle_to(10);
    beat(h3, 1'b1, 1'b0);
    chk("fwd_data", M_AXIS_TDATA, h3);
    idle_to(60);
    chk("single_drop", DROP_CNT, 0);

    // Just below level, with FIFO_FULL for the second half: nothing happens.
    do_reset();
    for (int i = 0; i < 60; i++) beat(below, 1'b1, (i >= 30));
    idle_to(64);
    chk("below_drop", DROP_CNT, 0);

    // 150 consecutive hits from cycle 3: 100-beat event, 2-cycle gap, re-trigger at 105.
    do_reset();
    push(16'd3, l0, 100, 100, 0, 0);
    push(16'd105, l0, 86, 86, 2, 0);
    idle_to(3);
    repeat (150) beat(l0, 1'b1, 1'b0);
    idle_to(200);

    // FIFO_FULL in IDLE drops 5 hits; toggling FIFO_FULL in ACQUIRE and hits in HOLDOFF do not.
    do_reset();
    idle_to(2);
    repeat (5) beat(l0, 1'b1, 1'b1);
    idle_to(10);
    chk("drop_five", DROP_CNT, 5);
    push(16'd10, h3, 49, 49, 0, 0);
    beat(h3, 1'b1, 1'b0);
    for (int i = 11; i < 20; i++) beat(128'h0, 1'b1, i[0]);
    beat(l0, 1'b1, 1'b1);
    for (int i = 21; i < 59; i++) beat(128'h0, 1'b1, i[0]);
    repeat (2) beat(l0, 1'b1, 1'b1);
    idle_to(70);
    chk("drop_after_acq", DROP_CNT, 5);

    // Negative full scale triggers; 3 invalid (hit-valued) beats stretch the event by 3 cycles.
    do_reset();
    push(16'd4, neg7, 39, 42, 0, 0);
    idle_to(4);
    beat(neg7, 1'b1, 1'b0);
    idle_to(15);
    repeat (3) beat(pos_fs, 1'b0, 1'b0);
    idle_to(50);
    push(16'd50, m409, 39, 39, 0, 0);
    beat(m409, 1'b1, 1'b0);
    idle_to(95);

    // Reset at beat 20 of an event: no finalize, counter restarts.
    do_reset();
    push(16'd2, l0, 0, 0, 0, 1);
    idle_to(2);
    beat(l0, 1'b1, 1'b0);
    idle_to(22);
    AXIS_ARESET = 1'b1;
    beat(128'h0, 1'b1, 1'b0);
    chk("midrst_start", START_TRG, 0);
    chk("midrst_finalize", FINALIZE_TRG, 0);
    chk("midrst_ts", TIME_STAMP, 0);
    AXIS_ARESET = 1'b0;
    cyc = 0;
    push(16'd5, l0, 39, 39, 0, 0);
    idle_to(5);
    beat(l0, 1'b1, 1'b0);
    idle_to(50);

    chk("queue_drained", exp_q.size(), 0);
    chk("no_open_event", in_ev, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
